// File: rtl/sdc_controller.sv
// Shutdown-circuit relay controller: supervises loop inputs and a watchdog heartbeat, and closes the relay on an activation edge.
// Optional feature: define SDC_BUTTON_DEBOUNCE_EN to filter both activation buttons with a counter debounce.
module sdc_controller #(
  parameter int N_LOOPS         = 4,
  parameter int CLOSE_DELAY     = 16,
  parameter int WD_TIMEOUT      = 1000,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic               Clk,
  input  logic               Power_on_Reset_n,
  input  logic               AS_close_SDC,
  input  logic               AS_driving_mode,
  input  logic               TS_Activation_Button_cockpit,
  input  logic               TS_Activation_Button_external,
  input  logic               Watchdog,
  input  logic [N_LOOPS-1:0] Shutdown_loop,
  input  logic               Fault_clear,
  output logic               To_SDC_relais,
  output logic               SDC_is_Ready,
  output logic [2:0]         SDC_state,
  output logic [N_LOOPS-1:0] Loop_fault
);
  localparam int SW  = N_LOOPS + 6;
  localparam int WDW = $clog2(WD_TIMEOUT + 1);
  localparam int CDW = $clog2(CLOSE_DELAY + 1);
  localparam logic [WDW-1:0] WD_MAX     = WDW'(WD_TIMEOUT);
  localparam logic [CDW-1:0] CLOSE_LAST = CDW'(CLOSE_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READY   = 3'd1,
    CLOSING = 3'd2,
    CLOSED  = 3'd3,
    FAULT   = 3'd4
  } state_t;

  // All asynchronous inputs share one two-stage synchroniser.
  logic [SW-1:0] raw_in;
  logic [SW-1:0] sync1_reg;
  logic [SW-1:0] sync2_reg;

  assign raw_in = {Shutdown_loop, Fault_clear, Watchdog, TS_Activation_Button_external,
                   TS_Activation_Button_cockpit, AS_driving_mode, AS_close_SDC};

  always_ff @(posedge Clk or negedge Power_on_Reset_n) begin
    if (!Power_on_Reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  logic               as_close_s;
  logic               mode_s;
  logic               wd_s;
  logic               fault_clear_s;
  logic [1:0]         btn_s;
  logic [N_LOOPS-1:0] loop_s;

  assign as_close_s    = sync2_reg[0];
  assign mode_s        = sync2_reg[1];
  assign btn_s         = sync2_reg[3:2];
  assign wd_s          = sync2_reg[4];
  assign fault_clear_s = sync2_reg[5];
  assign loop_s        = sync2_reg[SW-1:6];

  // Watchdog age counter; starts saturated so the heartbeat must be seen before READY.
  logic           wd_d_reg;
  logic [WDW-1:0] wd_cnt_reg;
  logic           wd_ok;

  always_ff @(posedge Clk or negedge Power_on_Reset_n) begin
    if (!Power_on_Reset_n) begin
      wd_d_reg   <= 1'b0;
      wd_cnt_reg <= WD_MAX;
    end else begin
      wd_d_reg <= wd_s;
      if (wd_s != wd_d_reg)
        wd_cnt_reg <= '0;
      else if (wd_cnt_reg != WD_MAX)
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  assign wd_ok = (wd_cnt_reg < WD_MAX);

  // btn_f[0] = cockpit, btn_f[1] = external.
  logic [1:0] btn_f;

`ifdef SDC_BUTTON_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
      logic [DBW-1:0] run_reg;
      logic           filt_reg;

      always_ff @(posedge Clk or negedge Power_on_Reset_n) begin
        if (!Power_on_Reset_n) begin
          run_reg  <= '0;
          filt_reg <= 1'b0;
        end else if (btn_s[gi] == filt_reg) begin
          run_reg <= '0;
        end else if (run_reg == DB_LAST) begin
          filt_reg <= btn_s[gi];
          run_reg  <= '0;
        end else begin
          run_reg <= run_reg + 1'b1;
        end
      end

      assign btn_f[gi] = filt_reg;
    end
  endgenerate
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES > 0);
  assign btn_f = btn_s;
`endif

  logic act;
  logic act_d1_reg;
  logic act_rise;
  logic loop_ok;

  assign act      = mode_s ? btn_f[1] : btn_f[0];
  assign act_rise = act & ~act_d1_reg;
  assign loop_ok  = (&loop_s) & wd_ok;

  always_ff @(posedge Clk or negedge Power_on_Reset_n) begin
    if (!Power_on_Reset_n)
      act_d1_reg <= 1'b0;
    else
      act_d1_reg <= act;
  end

  state_t         state_reg;
  state_t         state_next;
  logic [CDW-1:0] close_cnt_reg;
  logic           relay_on;

  always_ff @(posedge Clk or negedge Power_on_Reset_n) begin
    if (!Power_on_Reset_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Loop loss outranks a commanded open, which outranks close-delay expiry.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (loop_ok) state_next = READY;
      READY: begin
        if (!loop_ok)                     state_next = IDLE;
        else if (act_rise && as_close_s)  state_next = CLOSING;
      end
      CLOSING: begin
        if (!loop_ok)                        state_next = FAULT;
        else if (!as_close_s)                state_next = IDLE;
        else if (close_cnt_reg == CLOSE_LAST) state_next = CLOSED;
      end
      CLOSED: begin
        if (!loop_ok)         state_next = FAULT;
        else if (!as_close_s) state_next = IDLE;
      end
      FAULT:   if (fault_clear_s && loop_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Power_on_Reset_n) begin
    if (!Power_on_Reset_n)
      close_cnt_reg <= '0;
    else if (state_reg == CLOSING)
      close_cnt_reg <= close_cnt_reg + 1'b1;
    else
      close_cnt_reg <= '0;
  end

  assign relay_on = (state_reg == CLOSING) || (state_reg == CLOSED);

  always_ff @(posedge Clk or negedge Power_on_Reset_n) begin
    if (!Power_on_Reset_n)
      Loop_fault <= '0;
    else if (state_reg == FAULT && state_next == IDLE)
      Loop_fault <= '0;
    else if (relay_on)
      Loop_fault <= Loop_fault | ~loop_s;
  end

  assign To_SDC_relais = relay_on;
  assign SDC_is_Ready  = (state_reg == READY) || relay_on;
  assign SDC_state     = state_reg;

endmodule
